regfile_mp: RTL

Parametrised multi-read-port register file with a per-register pending-write scoreboard, for the pipelined processor core. Reads are synchronous with one-cycle registered outputs. Each read reports whether its data is valid or still awaiting an in-flight write. Sits between decode (reservations and operand reads) and writeback (register writes).

---
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_mp.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Register-file bus: two-port-class reads, writeback write, scoreboard reserve/flush.
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NREAD    = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NREAD-1:0]        rd_en;
    logic [NREAD*AW-1:0]     rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_valid;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic                    flush;
    logic [NUM_REGS-1:0]     pending;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_valid, pending
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_valid, pending
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard; reads have 1-cycle registered latency.
// No backpressure. Optional write-to-read forwarding under macro REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic                wr_ok;
    logic                rsv_ok;

    logic [AW-1:0]       ra     [NREAD];
    logic [DATA_W-1:0]   rdat_d [NREAD];
    logic [DATA_W-1:0]   rdat_q [NREAD];
    logic [NREAD-1:0]    rvld_d;
    logic [NREAD-1:0]    rvld_q;

    assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    // Reserve is applied last: it belongs to a younger instruction than the write.
    always_comb begin
        pend_d = bus.flush ? '0 : pend_q;
        if (wr_ok)  pend_d[bus.wr_addr]  = 1'b0;
        if (rsv_ok) pend_d[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            pend_q <= '0;
        end else begin
            if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            ra[i] = bus.rd_addr[i*AW +: AW];
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rdat_d[i] = regs[ra[i]];
            rvld_d[i] = ~pend_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.wr_addr == ra[i])) begin
                rdat_d[i] = bus.wr_data;
                rvld_d[i] = !(rsv_ok && (bus.rsv_addr == ra[i]));
            end
`endif
            if ((ZERO_REG != 0) && (ra[i] == '0)) begin
                rdat_d[i] = '0;
                rvld_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREAD; i++) rdat_q[i] <= '0;
            rvld_q <= '0;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                if (bus.rd_en[i]) rdat_q[i] <= rdat_d[i];
            end
            rvld_q <= bus.rd_en & rvld_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rdat_q[i];
        end
    end

    assign bus.rd_valid = rvld_q;
    assign bus.pending  = pend_q;
endmodule
